delay_nu_ctrl: RTL and testbench

- Clocked, multi-channel successor to the single-unit request delay element.
- Each channel carries a 2-phase (toggle) request: every transition on inR[i] is reproduced on outR[i] exactly D clock cycles later.
- D is one shared delay, programmable at run time in the range 1..MAX_DLY.
- Sits between clocked control stages that need matched or tunable request latency; reset forces all requests low, as the unit delay does.

---
 rtl/delay_nu_pkg.sv | 33 +++
 rtl/delay_nu_chan.sv | 115 +++++++++++
 rtl/delay_nu_ctrl.sv | 86 ++++++++
 tb/tb_delay_nu_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/delay_nu_pkg.sv
// Shared definitions for the multi-channel programmable request delay.
// Contents:
//   cnt_width    - width of the delay configuration and the channel counters
//   chan_state_t - channel FSM states (IDLE, PEND)
//   clamp_dly    - maps a requested delay onto the legal range 1..max_dly
package delay_nu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } chan_state_t;

  // Bits needed to hold any value in 0..max_dly.
  function automatic int cnt_width(input int max_dly);
    return $clog2(max_dly + 1);
  endfunction

  // A delay of 0 cannot be honoured, so it becomes 1.
  // Anything above max_dly saturates at max_dly.
  function automatic int unsigned clamp_dly(input int unsigned req,
                                            input int unsigned max_dly);
    int unsigned res;
    if (req == 32'd0) begin
      res = 32'd1;
    end else if (req > max_dly) begin
      res = max_dly;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/delay_nu_chan.sv
// One request channel of delay_nu_ctrl.
// A 2-phase request toggle seen on inR is reproduced on outR dly_cur edges later.
// Only one event can be in flight at a time. An event that arrives while the
// counter is still running is dropped, and the sticky ovf bit is set.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   inR      - 2-phase request input
//   dly_cur  - delay in force (1..MAX_DLY), shared by all channels
//   ovf_clr  - clears ovf on the next edge (a simultaneous drop wins)
//   outR     - delayed 2-phase request (registered)
//   busy     - an event is in flight (registered state)
//   ovf      - sticky drop flag (registered)
//   ev       - combinational event detect, used by the parent for config accept
module delay_nu_chan
  import delay_nu_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inR,
  input  logic [CNT_W-1:0] dly_cur,
  input  logic             ovf_clr,
  output logic             outR,
  output logic             busy,
  output logic             ovf,
  output logic             ev
);

  chan_state_t      state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [CNT_W-1:0] reload_s;
  logic             inr_q_r;
  logic             out_r, out_nxt;
  logic             ovf_r, ovf_nxt;
  logic             drop_s;
  logic             ev_s;

  assign ev_s = inR ^ inr_q_r;
  // The counter holds the remaining cycles minus one. This gives exactly
  // dly_cur edges between the detecting edge and the toggling edge.
  assign reload_s = dly_cur - CNT_W'(1);

  // Next-state, counter, output toggle and drop detection.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    out_nxt   = out_r;
    drop_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (ev_s) begin
          cnt_nxt   = reload_s;
          state_nxt = PEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      PEND: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_nxt = cnt_r - CNT_W'(1);
          drop_s  = ev_s;
        end else begin
          out_nxt = ~out_r;
          // A new event on the emitting edge chains straight into the next one.
          if (ev_s) begin
            cnt_nxt   = reload_s;
            state_nxt = PEND;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sticky overflow flag. A drop on the same edge as a clear wins.
  always_comb begin
    ovf_nxt = ovf_r;
    if (drop_s) begin
      ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = ovf_r;
    end
  end

  // Channel state registers. Reset discards any pending event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      inr_q_r <= 1'b0;
      out_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      inr_q_r <= inR;
      out_r   <= out_nxt;
      ovf_r   <= ovf_nxt;
    end
  end

  assign outR = out_r;
  assign busy = (state_r == PEND);
  assign ovf  = ovf_r;
  assign ev   = ev_s;

endmodule

// File: rtl/delay_nu_ctrl.sv
// Multi-channel clocked request delay with a run-time programmable delay.
// Each toggle on inR[i] reappears on outR[i] exactly dly_cur edges later.
// The delay can only be changed when nothing is in flight and no event is
// arriving. A rejected load gives a one-cycle cfg_err pulse.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   inR/outR - 2-phase request inputs / delayed outputs, CH bits
//   dly_cfg  - requested delay
//   cfg_load - strobe to adopt dly_cfg
//   cfg_err  - one-cycle pulse after a rejected cfg_load
//   busy     - per-channel event in flight
//   ovf      - per-channel sticky dropped-event flag
//   ovf_clr  - clears all ovf bits
//   dly_cur  - delay currently in force
module delay_nu_ctrl
  import delay_nu_pkg::*;
#(
  parameter int CH      = 4,
  parameter int MAX_DLY = 16,
  parameter int DEF_DLY = 1,
  parameter int CNT_W   = cnt_width(MAX_DLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    inR,
  output logic [CH-1:0]    outR,
  input  logic [CNT_W-1:0] dly_cfg,
  input  logic             cfg_load,
  output logic             cfg_err,
  output logic [CH-1:0]    busy,
  output logic [CH-1:0]    ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] dly_cur
);

  logic [CH-1:0]    ev_s;
  logic [CH-1:0]    busy_s;
  logic [CNT_W-1:0] dly_r, dly_nxt;
  logic             err_r, err_nxt;
  logic             accept_s;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    delay_nu_chan #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .inR     (inR[i]),
      .dly_cur (dly_r),
      .ovf_clr (ovf_clr),
      .outR    (outR[i]),
      .busy    (busy_s[i]),
      .ovf     (ovf[i]),
      .ev      (ev_s[i])
    );
  end

  // Accepting a load only when fully quiescent keeps every in-flight event
  // timed by the delay that was in force when it was detected.
  assign accept_s = cfg_load && (busy_s == {CH{1'b0}}) && (ev_s == {CH{1'b0}});

  // Config update and reject flag.
  always_comb begin
    dly_nxt = dly_r;
    err_nxt = 1'b0;
    if (accept_s) begin
      dly_nxt = CNT_W'(clamp_dly(32'(dly_cfg), 32'(MAX_DLY)));
    end else begin
      err_nxt = cfg_load;
    end
  end

  // Config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_r <= CNT_W'(DEF_DLY);
      err_r <= 1'b0;
    end else begin
      dly_r <= dly_nxt;
      err_r <= err_nxt;
    end
  end

  assign dly_cur = dly_r;
  assign cfg_err = err_r;
  assign busy    = busy_s;

endmodule

// File: tb/tb_delay_nu_ctrl.sv
// Directed table-driven bench for delay_nu_ctrl with CH=4, MAX_DLY=16 and DEF_DLY=1.
// Each row gives the inputs that are driven before an edge and the outputs
// expected after that edge.
module tb_delay_nu_ctrl;

  localparam int CNT_W = 5;

  typedef struct {
    logic             rst;
    logic [3:0]       in_r;
    logic             ld;
    logic [CNT_W-1:0] cfg;
    logic             clr;
    logic [3:0]       e_out;
    logic [3:0]       e_busy;
    logic [3:0]       e_ovf;
    logic             e_err;
    logic [CNT_W-1:0] e_dly;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [3:0]       inR;
  logic [3:0]       outR;
  logic [CNT_W-1:0] dly_cfg;
  logic             cfg_load;
  logic             cfg_err;
  logic [3:0]       busy;
  logic [3:0]       ovf;
  logic             ovf_clr;
  logic [CNT_W-1:0] dly_cur;

  int n_vec;
  int n_bad;
  vec_t vecs[$];

  delay_nu_ctrl #(.CH(4), .MAX_DLY(16), .DEF_DLY(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .inR      (inR),
    .outR     (outR),
    .dly_cfg  (dly_cfg),
    .cfg_load (cfg_load),
    .cfg_err  (cfg_err),
    .busy     (busy),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .dly_cur  (dly_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] i, input logic ld,
                     input logic [CNT_W-1:0] c, input logic cl,
                     input logic [3:0] eo, input logic [3:0] eb,
                     input logic [3:0] ev, input logic ee,
                     input logic [CNT_W-1:0] ed);
    vec_t v;
    v.rst = r; v.in_r = i; v.ld = ld; v.cfg = c; v.clr = cl;
    v.e_out = eo; v.e_busy = eb; v.e_ovf = ev; v.e_err = ee; v.e_dly = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int n;
    n_vec = 0; n_bad = 0;
    rst = 1'b1; inR = 4'b0000; cfg_load = 1'b0; dly_cfg = 5'd0; ovf_clr = 1'b0;

    // Reset, then a single toggle on channel 0 with the default D=1.
    for (int k = 0; k < 3; k++) add(1'b1, 4'b0000, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 5'd1);
    add(1'b0, 4'b0000, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 5'd1);
    add(1'b0, 4'b0001, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 5'd1);
    add(1'b0, 4'b0001, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 5'd1);
    add(1'b0, 4'b0001, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 5'd1);
    // D=5 on channel 2.
    add(1'b0, 4'b0001, 1'b1, 5'd5, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 5'd5);
    add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0100, 4'b0000, 1'b0, 5'd5);
    for (int k = 0; k < 4; k++) add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0100, 4'b0000, 1'b0, 5'd5);
    add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 5'd5);
    // dly_cfg=0 becomes D=1.
    add(1'b0, 4'b0101, 1'b1, 5'd0, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 5'd1);
    add(1'b0, 4'b0001, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0100, 4'b0000, 1'b0, 5'd1);
    add(1'b0, 4'b0001, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 5'd1);
    // dly_cfg=20 clamps to D=16.
    add(1'b0, 4'b0001, 1'b1, 5'd20, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 5'd16);
    add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0100, 4'b0000, 1'b0, 5'd16);
    for (int k = 0; k < 15; k++) add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0100, 4'b0000, 1'b0, 5'd16);
    add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 5'd16);
    // D=3: back-to-back toggles on channel 1 at k and k+3, plus a load rejected while PEND.
    add(1'b0, 4'b0101, 1'b1, 5'd3, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 5'd3);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0010, 4'b0000, 1'b0, 5'd3);
    add(1'b0, 4'b0111, 1'b1, 5'd7, 1'b0, 4'b0101, 4'b0010, 4'b0000, 1'b1, 5'd3);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0010, 4'b0000, 1'b0, 5'd3);
    add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0010, 4'b0000, 1'b0, 5'd3);
    add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0010, 4'b0000, 1'b0, 5'd3);
    add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0010, 4'b0000, 1'b0, 5'd3);
    add(1'b0, 4'b0101, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 5'd3);
    // A load on the same edge as an event is rejected.
    add(1'b0, 4'b0111, 1'b1, 5'd4, 1'b0, 4'b0101, 4'b0010, 4'b0000, 1'b1, 5'd3);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0010, 4'b0000, 1'b0, 5'd3);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0010, 4'b0000, 1'b0, 5'd3);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0000, 4'b0000, 1'b0, 5'd3);
    // D=4 overflow on channel 0, then ovf_clr alone.
    add(1'b0, 4'b0111, 1'b1, 5'd4, 1'b0, 4'b0111, 4'b0000, 4'b0000, 1'b0, 5'd4);
    add(1'b0, 4'b0110, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0001, 4'b0000, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0001, 4'b0001, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0001, 4'b0001, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0001, 4'b0001, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0110, 4'b0000, 4'b0001, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 5'd4);
    // A drop that coincides with ovf_clr sets ovf (set wins).
    add(1'b0, 4'b0110, 1'b0, 5'd0, 1'b0, 4'b0110, 4'b0001, 4'b0000, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b1, 4'b0110, 4'b0001, 4'b0001, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0110, 4'b0001, 4'b0001, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0110, 4'b0001, 4'b0001, 1'b0, 5'd4);
    add(1'b0, 4'b0111, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b0000, 4'b0001, 1'b0, 5'd4);
    // D=8: toggle all channels, then reset mid-flight with inR held high.
    add(1'b0, 4'b0111, 1'b1, 5'd8, 1'b0, 4'b0111, 4'b0000, 4'b0001, 1'b0, 5'd8);
    add(1'b0, 4'b1000, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b1111, 4'b0001, 1'b0, 5'd8);
    for (int k = 0; k < 3; k++) add(1'b0, 4'b1000, 1'b0, 5'd0, 1'b0, 4'b0111, 4'b1111, 4'b0001, 1'b0, 5'd8);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b1111, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 5'd1);
    add(1'b0, 4'b1111, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 5'd1);
    add(1'b0, 4'b1111, 1'b0, 5'd0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 5'd1);

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      rst = vecs[r].rst; inR = vecs[r].in_r; cfg_load = vecs[r].ld;
      dly_cfg = vecs[r].cfg; ovf_clr = vecs[r].clr;
      @(posedge clk);
      #1;
      n_vec++;
      if (outR !== vecs[r].e_out || busy !== vecs[r].e_busy || ovf !== vecs[r].e_ovf ||
          cfg_err !== vecs[r].e_err || dly_cur !== vecs[r].e_dly) begin
        n_bad++;
        $display("FAIL row %0d: outR=%b busy=%b ovf=%b err=%b dly=%0d, expected outR=%b busy=%b ovf=%b err=%b dly=%0d",
                 r, outR, busy, ovf, cfg_err, dly_cur, vecs[r].e_out, vecs[r].e_busy,
                 vecs[r].e_ovf, vecs[r].e_err, vecs[r].e_dly);
      end
    end

    // Hand sequence: load exactly MAX_DLY, then measure the channel 3 latency.
    @(negedge clk);
    cfg_load = 1'b1; dly_cfg = 5'd16;
    @(posedge clk);
    #1;
    chk("dly_max_load", int'(dly_cur), 16);
    @(negedge clk);
    cfg_load = 1'b0; inR = 4'b0111;
    @(posedge clk);
    #1;
    n = 0;
    while (outR[3] == 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_max", n, 16);
    chk("outR_after_max", int'(outR), 4'b0111);
    chk("busy_after_max", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
